activity_sequencer: RTL

- Automated controller for the bank of activity-generator instances that load the TDC sensor.
- Replaces manual button/switch toggling of the trig/en vectors with a programmable run.
- A run is a sequence of toggle bursts separated by quiet gaps, either at one fixed activity level or sweeping from 1 generator up to a maximum.
- Emits a burst marker and a done pulse for the ILA, so captured TDC samples can be aligned to activity windows.

---
 rtl/activity_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/activity_sequencer.sv
// Programmable run controller for the activity-generator bank: toggle bursts
// separated by quiet gaps, at a fixed level or sweeping 1..level_max.
module activity_sequencer #(
    parameter int g_NUM   = 16,
    parameter int g_CNT_W = 16
) (
    input  logic               clkActivity,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         level_max,
    input  logic               mode,
    input  logic [g_CNT_W-1:0] on_cycles,
    input  logic [g_CNT_W-1:0] off_cycles,
    input  logic [7:0]         repeats,
    output logic [g_NUM-1:0]   trig,
    output logic [g_NUM-1:0]   en,
    output logic [3:0]         cur_level,
    output logic               busy,
    output logic               burst_active,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    localparam int unsigned        NUM_U   = g_NUM;
    localparam logic [3:0]         LVL_CAP = (g_NUM > 15) ? 4'd15 : 4'(g_NUM);
    localparam logic [g_CNT_W-1:0] CNT_ONE = g_CNT_W'(1);

    state_t               state_q, state_n;
    logic [g_CNT_W-1:0]   cnt_q, cnt_n;
    logic [g_CNT_W-1:0]   on_len_q, on_len_n;
    logic [g_CNT_W-1:0]   off_len_q, off_len_n;
    logic [7:0]           rep_q, rep_n;
    logic [7:0]           rep_len_q, rep_len_n;
    logic [7:0]           rep_inc;
    logic [3:0]           lvl_max_q, lvl_max_n;
    logic [3:0]           lvl_clamp;
    logic                 mode_q, mode_n;
    logic                 start_q;
    logic                 start_edge;
    logic [g_NUM-1:0]     trig_q, trig_n;
    logic [g_NUM-1:0]     en_q, en_n;
    logic [3:0]           lvl_q, lvl_n;
    logic                 busy_q, busy_n;
    logic                 burst_q, burst_n;
    logic                 done_q, done_n;

    function automatic logic [g_NUM-1:0] therm(input logic [3:0] lvl);
        logic [g_NUM-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_U; i++) begin
            r[i] = (32'(lvl) > i);
        end
        return r;
    endfunction

    assign start_edge = start & ~start_q;
    assign lvl_clamp  = (32'(level_max) > NUM_U) ? LVL_CAP : level_max;
    assign rep_inc    = rep_q + 8'd1;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        rep_n     = rep_q;
        on_len_n  = on_len_q;
        off_len_n = off_len_q;
        rep_len_n = rep_len_q;
        lvl_max_n = lvl_max_q;
        mode_n    = mode_q;
        trig_n    = '0;
        en_n      = en_q;
        lvl_n     = lvl_q;
        busy_n    = busy_q;
        burst_n   = 1'b0;
        done_n    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge && !abort) begin
                    on_len_n  = (on_cycles  == '0) ? CNT_ONE : on_cycles;
                    off_len_n = (off_cycles == '0) ? CNT_ONE : off_cycles;
                    rep_len_n = (repeats == 8'd0) ? 8'd1 : repeats;
                    lvl_max_n = lvl_clamp;
                    mode_n    = mode;
                    rep_n     = '0;
                    cnt_n     = '0;
                    if (level_max == 4'd0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        en_n    = '0;
                        lvl_n   = '0;
                    end else begin
                        state_n = S_ARM;
                        lvl_n   = mode ? 4'd1 : lvl_clamp;
                        en_n    = therm(mode ? 4'd1 : lvl_clamp);
                        busy_n  = 1'b1;
                    end
                end
            end
            S_ARM: begin
                state_n = S_BURST;
                cnt_n   = '0;
                burst_n = 1'b1;
                trig_n  = ~trig_q & en_q;
            end
            S_BURST: begin
                if (cnt_q == on_len_q - CNT_ONE) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt_q + CNT_ONE;
                    burst_n = 1'b1;
                    trig_n  = ~trig_q & en_q;
                end
            end
            S_GAP: begin
                if (cnt_q == off_len_q - CNT_ONE) begin
                    cnt_n = '0;
                    if (rep_inc < rep_len_q) begin
                        state_n = S_ARM;
                        rep_n   = rep_inc;
                    end else if (mode_q && (lvl_q < lvl_max_q)) begin
                        state_n = S_ARM;
                        rep_n   = '0;
                        lvl_n   = lvl_q + 4'd1;
                        en_n    = therm(lvl_q + 4'd1);
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        en_n    = '0;
                        lvl_n   = '0;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides whatever the state wanted and suppresses done.
        if (abort && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            trig_n  = '0;
            en_n    = '0;
            lvl_n   = '0;
            busy_n  = 1'b0;
            burst_n = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clkActivity) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rep_q     <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            rep_len_q <= '0;
            lvl_max_q <= '0;
            mode_q    <= 1'b0;
            start_q   <= 1'b1;
            trig_q    <= '0;
            en_q      <= '0;
            lvl_q     <= '0;
            busy_q    <= 1'b0;
            burst_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            rep_q     <= rep_n;
            on_len_q  <= on_len_n;
            off_len_q <= off_len_n;
            rep_len_q <= rep_len_n;
            lvl_max_q <= lvl_max_n;
            mode_q    <= mode_n;
            start_q   <= start;
            trig_q    <= trig_n;
            en_q      <= en_n;
            lvl_q     <= lvl_n;
            busy_q    <= busy_n;
            burst_q   <= burst_n;
            done_q    <= done_n;
        end
    end

    assign trig         = trig_q;
    assign en           = en_q;
    assign cur_level    = lvl_q;
    assign busy         = busy_q;
    assign burst_active = burst_q;
    assign done         = done_q;

endmodule
